alu_div_seq: RTL and testbench
==============================

Name: alu_div_seq

Overview:
- Sequential 16-by-8 unsigned divider for the S1C88 core.
- Offloads DIV from the combinational ALU path. The CPU microcode issues operands with a start pulse, stalls on busy, and writes back result and flags on done.
- Result packing and flag semantics match the ALU's DIV convention: result[7:0] is the quotient, result[15:8] is the remainder.
- Retires BITS_PER_CYCLE quotient bits per clock using restoring division.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per RUN cycle. Legal values are 1, 2, 4, 8; any other value is an elaboration error.

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous reset, active-low
- start  input  1  request pulse; accepted only in IDLE
- dividend  input  16  A operand; sampled on the accepted start
- divisor  input  8  B operand; sampled on the accepted start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result and flags are valid in that cycle and held until the next accepted start
- result  output  16  {remainder, quotient}, or the dividend on the error paths
- flags  output  4  bit 0 Z, bit 1 C, bit 2 V, bit 3 S

Behaviour:
- Reset: asynchronous, active-low.
  - Forces state IDLE and clears busy, done, result, flags and all internal registers to 0.
  - Reset asserted mid-RUN abandons the operation; no done is produced.
- States and transitions:
  - IDLE, RUN, DONE.
  - IDLE with start=1: latch operands, then evaluate in this priority order:
    1. divisor==0: set result=dividend, flags Z=0 C=0 V=1 S=1; go to DONE.
    2. dividend[15:8] >= divisor (quotient overflow): set result=dividend, flags Z=0 C=0 V=1 S=dividend[7]; go to DONE.
    3. Otherwise: partial remainder = dividend[15:8], shift register = dividend[7:0], step count = 0; go to RUN.
  - RUN: each cycle performs BITS_PER_CYCLE restoring steps.
    - Each step: shift the remainder left by 1, bringing in the next dividend bit (9-bit compare against {1'b0, divisor}).
    - If the shifted remainder >= divisor: subtract, quotient bit = 1. Otherwise quotient bit = 0.
    - After 8/BITS_PER_CYCLE cycles: result = {rem[7:0], quot[7:0]}, Z = (result == 0), C = 0, V = 0, S = quot[7]; go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency, counted from the edge that samples start:
  - Normal path: done at edge 8/BITS_PER_CYCLE + 1 (9 cycles for BITS_PER_CYCLE=1).
  - Error paths: done at edge 1.
- start while busy: ignored, no queueing. start in the same cycle as done/DONE: ignored. The earliest new accept is the cycle after done.
- The operand inputs may change freely after the accepted start.
- result and flags are stable except on the update at the DONE transition.
- The remainder is always < divisor, so it fits in 8 bits. The internal remainder register is 9 bits wide to absorb the shift.

Optional Feature:
- ALU_DIV_ZERO_TRAP_EN
  - Defined: adds output port div_zero_trap (1 bit). It pulses for 1 cycle, coincident with done, only on the divisor==0 path. The CPU uses it to raise the zero-divide exception. Reset value 0.
  - Undefined: the port is absent. Division by zero is reported only through flags V=1 and S=1.

Decomposition:
- Shared package alu_pkg holds:
  - ALU flag index constants (ALU_FLAG_Z=0, C=1, V=2, S=3).
  - The ALUOP encodings, including ALUOP_DIV.
  - The DIV state typedef (IDLE/RUN/DONE).
  - This package also serves the combinational ALU.
- Sub-module alu_div_step: combinational single restoring step.
  - Inputs: 9-bit remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- 0x1234 / 0x56, BITS_PER_CYCLE=1 -> done at edge 9, result=0x1036, flags=4'b0000; busy high on edges 1-9, low after.
- 0x00FF / 0x01 -> result=0x00FF, flags=4'b1000 (S=1); repeat with BITS_PER_CYCLE=2/4/8 -> identical result, done at edges 5/3/2.
- 0x0000 / 0x05 -> result=0x0000, flags=4'b0001 (Z=1); 0x0100 / 0x01 -> overflow, done at edge 1, result=0x0100, flags=4'b0100.
- 0x1234 / 0x00 -> done at edge 1, result=0x1234, flags=4'b1100; with ALU_DIV_ZERO_TRAP_EN, div_zero_trap high only in the done cycle.
- start 0x1234/0x56 accepted; at edge 3 re-pulse start with 0x0000/0x01 and change the operand inputs -> ignored, final result still 0x1036; start asserted during the done cycle is ignored.
- reset_n low during RUN edge 4 -> busy, done, result and flags are 0 immediately; no done appears afterwards; the next start 0x0064/0x0A completes with result=0x000A.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: flag bit positions, ALU opcode encodings and the
// state type of the sequential divider. Used by the combinational ALU and
// by alu_div_seq.
package alu_pkg;

  localparam int ALU_FLAG_Z = 0;
  localparam int ALU_FLAG_C = 1;
  localparam int ALU_FLAG_V = 2;
  localparam int ALU_FLAG_S = 3;

  typedef enum logic [3:0] {
    ALUOP_ADD = 4'h0,
    ALUOP_ADC = 4'h1,
    ALUOP_SUB = 4'h2,
    ALUOP_SBC = 4'h3,
    ALUOP_AND = 4'h4,
    ALUOP_OR  = 4'h5,
    ALUOP_XOR = 4'h6,
    ALUOP_CMP = 4'h7,
    ALUOP_INC = 4'h8,
    ALUOP_DEC = 4'h9,
    ALUOP_MUL = 4'hA,
    ALUOP_DIV = 4'hB
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_div_seq_if.sv
// Handshake/operand bus between the CPU microcode (master) and the
// sequential divider (slave).
interface alu_div_seq_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;

  modport master (
    output start, dividend, divisor,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, result, flags
  );
endinterface

// File: rtl/alu_div_step.sv
// One restoring-division step: shift the partial remainder left by one,
// bring in the next dividend bit, subtract the divisor when it fits.
module alu_div_step (
  input  logic [8:0] rem_in,
  input  logic       bit_in,
  input  logic [7:0] divisor,
  output logic [8:0] rem_out,
  output logic       q_bit
);

  logic [8:0] shifted;
  logic       unused_rem_msb;

  // The incoming remainder is always below the divisor, so its MSB is zero.
  assign unused_rem_msb = rem_in[8];

  // Compare-and-subtract on the 9-bit shifted remainder.
  always_comb begin
    shifted = {rem_in[7:0], bit_in};
    rem_out = shifted;
    q_bit   = 1'b0;
    if (shifted >= {1'b0, divisor}) begin
      rem_out = shifted - {1'b0, divisor};
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_div_seq.sv
// Sequential 16-by-8 unsigned restoring divider for the S1C88 core.
// result = {remainder, quotient}; on divide-by-zero or quotient overflow the
// dividend is returned unchanged with V set. BITS_PER_CYCLE quotient bits are
// resolved per RUN cycle (1, 2, 4 or 8).
// Optional: define ALU_DIV_ZERO_TRAP_EN to add the div_zero_trap output,
// a pulse coincident with done on the divisor==0 path.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_div_seq_if.slave bus
`ifdef ALU_DIV_ZERO_TRAP_EN
  ,
  output logic         div_zero_trap
`endif
);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
    $error("alu_div_seq: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam int         CYCLES   = 8 / BITS_PER_CYCLE;
  localparam logic [3:0] LAST_CNT = 4'(CYCLES - 1);

  div_state_e  state_q, state_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;

  logic [8:0]                chain_rem [0:BITS_PER_CYCLE];
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic [7:0]                sr_next;

  assign chain_rem[0] = rem_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    alu_div_step u_step (
      .rem_in  (chain_rem[i]),
      .bit_in  (sr_q[7-i]),
      .divisor (divisor_q),
      .rem_out (chain_rem[i+1]),
      .q_bit   (q_bits[BITS_PER_CYCLE-1-i])
    );
  end

  // Consumed dividend bits leave at the top, new quotient bits enter at the
  // bottom, so after the last cycle sr holds the full quotient.
  assign sr_next = 8'({sr_q, q_bits});

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  // Next-state: accept/triage in IDLE, iterate in RUN, retire in DONE.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    flags_d   = flags_q;
    case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          divisor_d = bus.divisor;
          if (bus.divisor == 8'h00) begin
            result_d                = bus.dividend;
            flags_d                 = '0;
            flags_d[ALU_FLAG_V]     = 1'b1;
            flags_d[ALU_FLAG_S]     = 1'b1;
            state_d                 = DIV_DONE;
          end else if (bus.dividend[15:8] >= bus.divisor) begin
            result_d                = bus.dividend;
            flags_d                 = '0;
            flags_d[ALU_FLAG_V]     = 1'b1;
            flags_d[ALU_FLAG_S]     = bus.dividend[7];
            state_d                 = DIV_DONE;
          end else begin
            rem_d   = {1'b0, bus.dividend[15:8]};
            sr_d    = bus.dividend[7:0];
            cnt_d   = '0;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_d = chain_rem[BITS_PER_CYCLE];
        sr_d  = sr_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          result_d            = {chain_rem[BITS_PER_CYCLE][7:0], sr_next};
          flags_d             = '0;
          flags_d[ALU_FLAG_Z] = (result_d == 16'h0000);
          flags_d[ALU_FLAG_S] = sr_next[7];
          state_d             = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign bus.busy   = (state_q != DIV_IDLE);
  assign bus.done   = (state_q == DIV_DONE);
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

`ifdef ALU_DIV_ZERO_TRAP_EN
  logic trap_q, trap_d;

  // Trap is raised on a zero-divisor accept, which always lands in DONE next.
  always_comb begin
    trap_d = 1'b0;
    if (state_q == DIV_IDLE && bus.start && bus.divisor == 8'h00) trap_d = 1'b1;
  end

  // Trap pulse register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trap_q <= 1'b0;
    else          trap_q <= trap_d;
  end

  assign div_zero_trap = trap_q;
`endif

endmodule

// File: tb/tb_alu_div_seq.sv
// Testbench for alu_div_seq: four instances (BITS_PER_CYCLE 1/2/4/8) driven
// with a table of directed vectors, plus hand-written restart and reset
// sequences on the BITS_PER_CYCLE=1 instance.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_main = 1'b0;
  logic        start_aux = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_div_seq_if if1 ();
  alu_div_seq_if if2 ();
  alu_div_seq_if if4 ();
  alu_div_seq_if if8 ();

  assign if1.start = start_main;
  assign if2.start = start_aux;
  assign if4.start = start_aux;
  assign if8.start = start_aux;
  assign if1.dividend = dividend;
  assign if2.dividend = dividend;
  assign if4.dividend = dividend;
  assign if8.dividend = dividend;
  assign if1.divisor = divisor;
  assign if2.divisor = divisor;
  assign if4.divisor = divisor;
  assign if8.divisor = divisor;

  logic [3:0]  done_v, busy_v;
  logic [15:0] res_v [4];
  logic [3:0]  flg_v [4];
  logic [3:0]  trap_v;

  assign done_v = {if8.done, if4.done, if2.done, if1.done};
  assign busy_v = {if8.busy, if4.busy, if2.busy, if1.busy};
  assign res_v[0] = if1.result;
  assign res_v[1] = if2.result;
  assign res_v[2] = if4.result;
  assign res_v[3] = if8.result;
  assign flg_v[0] = if1.flags;
  assign flg_v[1] = if2.flags;
  assign flg_v[2] = if4.flags;
  assign flg_v[3] = if8.flags;

`ifdef ALU_DIV_ZERO_TRAP_EN
  alu_div_seq #(.BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1), .div_zero_trap(trap_v[0]));
  alu_div_seq #(.BITS_PER_CYCLE(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2), .div_zero_trap(trap_v[1]));
  alu_div_seq #(.BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(if4), .div_zero_trap(trap_v[2]));
  alu_div_seq #(.BITS_PER_CYCLE(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8), .div_zero_trap(trap_v[3]));
`else
  assign trap_v = 4'b0000;
  alu_div_seq #(.BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  alu_div_seq #(.BITS_PER_CYCLE(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  alu_div_seq #(.BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));
  alu_div_seq #(.BITS_PER_CYCLE(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8));
`endif

  typedef struct {
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] res;
    logic [3:0]  flg;
    bit          err;
  } vec_t;

  vec_t vecs [9];
  int   bpc_tab [4] = '{1, 2, 4, 8};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Issue one operation to all four instances and check latency, single
  // done pulse, busy profile (BITS_PER_CYCLE=1), result and flags.
  task automatic run_vec(input int idx, input vec_t v);
    int done_at [4];
    int pulses [4];
    int lat [4];
    int trap_at;
    for (int k = 0; k < 4; k++) begin
      done_at[k] = 0;
      pulses[k]  = 0;
      lat[k]     = v.err ? 1 : (8 / bpc_tab[k]) + 1;
    end
    trap_at = 0;
    @(negedge clk);
    dividend   = v.dividend;
    divisor    = v.divisor;
    start_main = 1'b1;
    start_aux  = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start_main = 1'b0;
        start_aux  = 1'b0;
        dividend   = 16'($urandom);
        divisor    = 8'($urandom);
      end
      for (int k = 0; k < 4; k++) begin
        if (done_v[k]) begin
          pulses[k]++;
          if (done_at[k] == 0) done_at[k] = n;
        end
      end
      if (trap_v[0] && trap_at == 0) trap_at = n;
      check($sformatf("v%0d busy edge %0d", idx, n), {31'b0, busy_v[0]}, {31'b0, n <= lat[0]});
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("v%0d bpc%0d done_edge", idx, bpc_tab[k]), done_at[k], lat[k]);
      check($sformatf("v%0d bpc%0d done_pulses", idx, bpc_tab[k]), pulses[k], 1);
      check($sformatf("v%0d bpc%0d result", idx, bpc_tab[k]), {16'h0, res_v[k]}, {16'h0, v.res});
      check($sformatf("v%0d bpc%0d flags", idx, bpc_tab[k]), {28'h0, flg_v[k]}, {28'h0, v.flg});
    end
`ifdef ALU_DIV_ZERO_TRAP_EN
    check($sformatf("v%0d trap_edge", idx), trap_at, (v.divisor == 8'h00) ? 1 : 0);
`endif
  endtask

  initial begin
    int done_at;
    int pulses;

    vecs[0] = '{16'h1234, 8'h56, 16'h1036, 4'b0000, 1'b0};
    vecs[1] = '{16'h00FF, 8'h01, 16'h00FF, 4'b1000, 1'b0};
    vecs[2] = '{16'h0000, 8'h05, 16'h0000, 4'b0001, 1'b0};
    vecs[3] = '{16'h0100, 8'h01, 16'h0100, 4'b0100, 1'b1};
    vecs[4] = '{16'h1234, 8'h00, 16'h1234, 4'b1100, 1'b1};
    vecs[5] = '{16'hFFFF, 8'hFF, 16'hFFFF, 4'b1100, 1'b1};
    vecs[6] = '{16'hFEFF, 8'hFF, 16'hFEFF, 4'b1000, 1'b0};
    vecs[7] = '{16'h0080, 8'h01, 16'h0080, 4'b1000, 1'b0};
    vecs[8] = '{16'h0064, 8'h0A, 16'h000A, 4'b0000, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset bpc%0d busy", bpc_tab[k]), {31'b0, busy_v[k]}, 0);
      check($sformatf("reset bpc%0d done", bpc_tab[k]), {31'b0, done_v[k]}, 0);
      check($sformatf("reset bpc%0d result", bpc_tab[k]), {16'h0, res_v[k]}, 0);
      check($sformatf("reset bpc%0d flags", bpc_tab[k]), {28'h0, flg_v[k]}, 0);
    end
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Restart while busy and start during the done cycle are both ignored.
    @(negedge clk);
    dividend   = 16'h1234;
    divisor    = 8'h56;
    start_main = 1'b1;
    done_at    = 0;
    pulses     = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        pulses++;
        if (done_at == 0) done_at = n;
      end
      check($sformatf("restart busy edge %0d", n), {31'b0, busy_v[0]}, {31'b0, n <= 9});
      start_main = 1'b0;
      if (n == 3 || n == 9) begin
        start_main = 1'b1;
        dividend   = 16'h0000;
        divisor    = 8'h01;
      end
      if (n == 4) begin
        dividend = 16'hABCD;
        divisor  = 8'h03;
      end
    end
    check("restart done_edge", done_at, 9);
    check("restart done_pulses", pulses, 1);
    check("restart result", {16'h0, res_v[0]}, 32'h1036);
    check("restart flags", {28'h0, flg_v[0]}, 0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    dividend   = 16'h1234;
    divisor    = 8'h56;
    start_main = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start_main = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("midreset busy", {31'b0, busy_v[0]}, 0);
    check("midreset done", {31'b0, done_v[0]}, 0);
    check("midreset result", {16'h0, res_v[0]}, 0);
    check("midreset flags", {28'h0, flg_v[0]}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) pulses++;
    end
    check("midreset no done/busy after", pulses, 0);
    run_vec(9, vecs[8]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
